// File: rtl/peak_interval_timer_pkg.sv
// Shared definitions for the peak interval timer: controller states, the legal
// NUM_PEAKS range and a constant-evaluable ceil(log2) helper.
package peak_interval_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

    localparam int NUM_PEAKS_MIN = 2;
    localparam int NUM_PEAKS_MAX = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/peak_interval_timer_rise.sv
// Registered rising-edge detector: rise is high in the first cycle d is seen
// high after having been low (or after reset).
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/peak_interval_timer.sv
// Times the first NUM_PEAKS peak edges after each piezo ramp edge and publishes
// the intervals (peak k minus peak 0) on an AXI-Stream master with overrun flagging.
module peak_interval_timer
    import peak_interval_timer_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int NUM_PEAKS  = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                piezo_ramp_trigger,
    input  logic                                peak_trigger,
    input  logic [DATA_WIDTH-1:0]               holdoff,
    output logic [(NUM_PEAKS-1)*DATA_WIDTH-1:0] m_axis_intervals_tdata,
    output logic                                m_axis_intervals_tvalid,
    input  logic                                m_axis_intervals_tready,
    output logic [clog2(NUM_PEAKS+1)-1:0]       peak_count,
    output logic                                err_timeout,
    output logic                                err_incomplete,
    output logic                                err_overrun
);

    localparam int CNT_W = clog2(NUM_PEAKS + 1);
    localparam int OUT_W = (NUM_PEAKS - 1) * DATA_WIDTH;

    if (NUM_PEAKS < NUM_PEAKS_MIN || NUM_PEAKS > NUM_PEAKS_MAX) begin : g_bad_num_peaks
        $error("peak_interval_timer: NUM_PEAKS must lie in 2..16");
    end

    state_t                  state_q, state_d;
    logic                    ramp_edge, peak_edge;
    logic [DATA_WIDTH-1:0]   counter_q, last_ts_q, since_last;
    logic [DATA_WIDTH-1:0]   ts_q [NUM_PEAKS];
    logic [CNT_W-1:0]        peak_count_q;
    logic [OUT_W-1:0]        tdata_q, intervals;
    logic                    tvalid_q;
    logic                    at_max, accept, last_peak;

    rise_detect u_ramp_rise (
        .clk  (clk),
        .rst  (rst),
        .d    (piezo_ramp_trigger),
        .rise (ramp_edge)
    );

    rise_detect u_peak_rise (
        .clk  (clk),
        .rst  (rst),
        .d    (peak_trigger),
        .rise (peak_edge)
    );

    // A ramp edge always takes priority, so a coincident peak is never timestamped.
    assign at_max     = (counter_q == {DATA_WIDTH{1'b1}});
    assign since_last = counter_q - last_ts_q;
    assign accept     = (state_q == ST_ARMED) && !ramp_edge && !at_max && peak_edge &&
                        ((peak_count_q == '0) || (since_last > holdoff));
    assign last_peak  = (peak_count_q == CNT_W'(NUM_PEAKS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (ramp_edge) state_d = ST_ARMED;
            ST_ARMED: begin
                if (ramp_edge)                state_d = ST_ARMED;
                else if (at_max)              state_d = ST_IDLE;
                else if (accept && last_peak) state_d = ST_PUBLISH;
            end
            ST_PUBLISH: state_d = ramp_edge ? ST_ARMED : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        err_incomplete = 1'b0;
        err_timeout    = 1'b0;
        err_overrun    = 1'b0;
        if (state_q == ST_ARMED) begin
            err_incomplete = ramp_edge;
            err_timeout    = !ramp_edge && at_max;
        end
        if (state_q == ST_PUBLISH) begin
            err_overrun = tvalid_q && !m_axis_intervals_tready;
        end
    end

    always_comb begin
        intervals = '0;
        for (int k = 1; k < NUM_PEAKS; k++) begin
            intervals[(k-1)*DATA_WIDTH +: DATA_WIDTH] = ts_q[k] - ts_q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter_q    <= '0;
            last_ts_q    <= '0;
            peak_count_q <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            // NOTE: the timestamp array is a handful of flops, not a RAM, so it
            // can be cleared here like any other register.
            for (int i = 0; i < NUM_PEAKS; i++) begin
                ts_q[i] <= '0;
            end
        end else begin
            if (ramp_edge) begin
                counter_q    <= '0;
                peak_count_q <= '0;
            end else if (state_q == ST_ARMED && !at_max) begin
                counter_q <= counter_q + DATA_WIDTH'(1);
            end

            if (accept) begin
                ts_q[peak_count_q] <= counter_q;
                last_ts_q          <= counter_q;
                peak_count_q       <= peak_count_q + CNT_W'(1);
            end

            // A publish reloads the output even when a transfer happens the same cycle.
            if (state_q == ST_PUBLISH) begin
                tdata_q  <= intervals;
                tvalid_q <= 1'b1;
            end else if (tvalid_q && m_axis_intervals_tready) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign m_axis_intervals_tdata  = tdata_q;
    assign m_axis_intervals_tvalid = tvalid_q;
    assign peak_count              = peak_count_q;

endmodule

// File: tb/tb_peak_interval_timer.sv
// Bench for peak_interval_timer: directed ramp/peak scenarios, a cycle-by-cycle
// reference model built on absolute cycle numbers, and literal spot checks.
module tb_peak_interval_timer;

    localparam int DW   = 8;
    localparam int NP   = 3;
    localparam int PW   = (NP - 1) * DW;
    localparam int CW   = 2;
    localparam int MAXC = (1 << DW) - 1;
    localparam int HLEN = 300;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ramp_trg = 1'b0;
    logic          peak_trg = 1'b0;
    logic          tready = 1'b1;
    logic [DW-1:0] holdoff = '0;
    logic [PW-1:0] tdata;
    logic          tvalid;
    logic [CW-1:0] pc;
    logic          e_to, e_inc, e_ov;

    peak_interval_timer #(.DATA_WIDTH(DW), .NUM_PEAKS(NP)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .piezo_ramp_trigger      (ramp_trg),
        .peak_trigger            (peak_trg),
        .holdoff                 (holdoff),
        .m_axis_intervals_tdata  (tdata),
        .m_axis_intervals_tvalid (tvalid),
        .m_axis_intervals_tready (tready),
        .peak_count              (pc),
        .err_timeout             (e_to),
        .err_incomplete          (e_inc),
        .err_overrun             (e_ov)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a ramp edge seen in cycle r means the counter reads
    // (c - r - 1) in cycle c; accepted peaks are kept as those counter values.
    int            cyc = 0;
    int            m_ramp_cyc = 0;
    bit            m_armed = 0, m_pub = 0, m_tvalid = 0;
    bit            prev_r = 0, prev_p = 0;
    logic [PW-1:0] m_tdata = '0;
    int            acc[$];

    always @(negedge clk) begin : model
        bit re, pe;
        int cnt;
        cyc++;
        if (rst) begin
            m_armed = 0; m_pub = 0; m_tvalid = 0; m_tdata = '0;
            acc.delete();
            prev_r = 0; prev_p = 0;
        end else begin
            re  = ramp_trg && !prev_r;
            pe  = peak_trg && !prev_p;
            cnt = cyc - m_ramp_cyc - 1;
            check("tvalid",         tvalid, m_tvalid);
            check("tdata",          tdata,  m_tdata);
            check("peak_count",     pc,     acc.size());
            check("err_incomplete", e_inc,  m_armed && re);
            check("err_timeout",    e_to,   m_armed && !re && cnt == MAXC);
            check("err_overrun",    e_ov,   m_pub && m_tvalid && !tready);

            if (m_tvalid && tready) m_tvalid = 0;
            if (m_pub) begin
                for (int k = 1; k < NP; k++)
                    m_tdata[(k-1)*DW +: DW] = DW'(acc[k] - acc[0]);
                m_tvalid = 1;
                m_pub    = 0;
            end else if (m_armed && !re) begin
                if (cnt == MAXC) begin
                    m_armed = 0;
                end else if (pe && (acc.size() == 0 || (cnt - acc[$]) > int'(holdoff))) begin
                    acc.push_back(cnt);
                    if (acc.size() == NP) begin
                        m_armed = 0;
                        m_pub   = 1;
                    end
                end
            end
            if (re) begin
                m_armed    = 1;
                m_ramp_cyc = cyc;
                acc.delete();
            end
            prev_r = ramp_trg;
            prev_p = peak_trg;
        end
    end

    // Per-scenario history of DUT outputs, indexed by cycle relative to the scenario start.
    logic          h_tvalid [HLEN];
    logic [PW-1:0] h_tdata  [HLEN];
    logic [CW-1:0] h_pc     [HLEN];
    logic          h_to     [HLEN];
    logic          h_inc    [HLEN];
    logic          h_ov     [HLEN];

    function automatic bit is_in(input int q[$], input int v);
        foreach (q[i]) if (q[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    // Called just after a rising edge; each cycle i drives 1-cycle trigger pulses.
    task automatic play(input int ramps[$], input int peaks[$], input int len);
        for (int i = 0; i < len; i++) begin
            ramp_trg = is_in(ramps, i);
            peak_trg = is_in(peaks, i);
            @(negedge clk);
            h_tvalid[i] = tvalid; h_tdata[i] = tdata; h_pc[i] = pc;
            h_to[i] = e_to; h_inc[i] = e_inc; h_ov[i] = e_ov;
            @(posedge clk);
            #1;
        end
        ramp_trg = 1'b0;
        peak_trg = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int rq[$];
        int pq[$];
        bit any_valid;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_tvalid", tvalid, 0);
        check("reset_tdata",  tdata,  0);
        check("reset_pc",     pc,     0);
        @(posedge clk);
        #1;

        // Nominal: ts 9, 24, 59 -> {50,15}, tvalid only at cycle 62.
        rq = {0}; pq = {10, 25, 60};
        play(rq, pq, 66);
        check("nom_pc_11",     h_pc[11],     1);
        check("nom_pc_61",     h_pc[61],     3);
        check("nom_tvalid_61", h_tvalid[61], 0);
        check("nom_tvalid_62", h_tvalid[62], 1);
        check("nom_tvalid_63", h_tvalid[63], 0);
        check("nom_tdata_62",  h_tdata[62],  {8'd50, 8'd15});

        // Holdoff: the edge at 13 falls inside the dead time.
        holdoff = 8'd5;
        rq = {0}; pq = {10, 13, 25, 60};
        play(rq, pq, 66);
        check("hold_pc_14",    h_pc[14],    1);
        check("hold_pc_26",    h_pc[26],    2);
        check("hold_pc_61",    h_pc[61],    3);
        check("hold_tdata_62", h_tdata[62], {8'd50, 8'd15});
        holdoff = '0;

        // Timeout: counter saturates at 255 in cycle 256; later peak stays ignored.
        rq = {0}; pq = {5, 259};
        play(rq, pq, 262);
        check("to_pulse_255", h_to[255], 0);
        check("to_pulse_256", h_to[256], 1);
        check("to_pulse_257", h_to[257], 0);
        check("to_pc_261",    h_pc[261], 1);
        any_valid = 0;
        for (int i = 0; i < 262; i++) any_valid |= h_tvalid[i];
        check("to_no_tvalid", any_valid, 0);

        // Incomplete plus tie: restart at 20 drops the coincident peak.
        rq = {0, 20}; pq = {10, 20, 30, 40, 50};
        play(rq, pq, 60);
        check("inc_pulse_19", h_inc[19], 0);
        check("inc_pulse_20", h_inc[20], 1);
        check("inc_pc_21",    h_pc[21],  0);
        check("inc_pc_31",    h_pc[31],  1);
        check("inc_tvalid_52", h_tvalid[52], 1);
        check("inc_tdata_52",  h_tdata[52],  {8'd20, 8'd10});

        // Overrun: no ready, second ramp overwrites the pending result.
        tready = 1'b0;
        rq = {0, 80}; pq = {10, 25, 60, 90, 100, 130};
        play(rq, pq, 150);
        check("ovr_tdata_62",   h_tdata[62],  {8'd50, 8'd15});
        check("ovr_pulse_61",   h_ov[61],     0);
        check("ovr_pulse_131",  h_ov[131],    1);
        check("ovr_tvalid_100", h_tvalid[100], 1);
        check("ovr_tvalid_131", h_tvalid[131], 1);
        check("ovr_tdata_140",  h_tdata[140], {8'd40, 8'd10});
        tready = 1'b1;
        rq = {}; pq = {};
        play(rq, pq, 3);
        check("ovr_xfer_valid", h_tvalid[0], 1);
        check("ovr_xfer_data",  h_tdata[0],  {8'd40, 8'd10});
        check("ovr_after_xfer", h_tvalid[1], 0);

        // Reset in the middle of a measurement, then a clean measurement.
        rq = {0}; pq = {10, 25};
        play(rq, pq, 30);
        check("rst_pc_before", h_pc[29], 2);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_tdata",  tdata,  0);
        check("rst_tvalid", tvalid, 0);
        check("rst_pc",     pc,     0);
        @(posedge clk);
        #1;
        rq = {0}; pq = {10, 25, 60};
        play(rq, pq, 66);
        check("post_rst_tvalid_62", h_tvalid[62], 1);
        check("post_rst_tdata_62",  h_tdata[62],  {8'd50, 8'd15});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
